// File: rtl/walk_multi.sv
// Multi-lane RHT recovery walker: RESTORE from checkpoint base to the faulting ticket, RECLAIM to the tail, then DONE.
// Optional WALK_PERF_EN adds saturating recovery/walk-cycle performance counters.
module walk_multi #(
    parameter int RHT_ID_WIDTH = 8,
    parameter int C_ADDR       = 2,
    parameter int K            = 32,
    parameter int WALK_W       = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rec_en,
    input  logic [RHT_ID_WIDTH-1:0]        rec_rht_id,
    input  logic [RHT_ID_WIDTH-1:0]        rht_id_out,
    input  logic                           walk_stall,
    output logic                           rec_ready,
    output logic                           rec_state,
    output logic                           in_reclaim,
    output logic [WALK_W-1:0]              walk_valid,
    output logic [WALK_W*RHT_ID_WIDTH-1:0] walk_idx,
    output logic [C_ADDR-1:0]              new_checkpoint,
    output logic                           rht_set_ptr,
    output logic [RHT_ID_WIDTH-1:0]        new_pointer
`ifdef WALK_PERF_EN
    ,
    output logic [31:0]                    perf_rec_cnt,
    output logic [31:0]                    perf_walk_cyc
`endif
);

    localparam int LOG_K = $clog2(K);

    typedef logic [RHT_ID_WIDTH-1:0] id_t;
    typedef enum logic [1:0] {S_IDLE, S_RESTORE, S_RECLAIM, S_DONE} state_t;

    localparam id_t BASE_MASK = ~id_t'(K - 1);
    localparam id_t WALK_STEP = id_t'(WALK_W);

    state_t      state_q, state_d;
    id_t         walk_point_q, walk_point_d;
    id_t         target_q, target_d;
    logic [C_ADDR-1:0] new_checkpoint_q, new_checkpoint_d;

    id_t  rem;
    id_t  target_inc;
    logic walking;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d          = state_q;
        walk_point_d     = walk_point_q;
        target_d         = target_q;
        new_checkpoint_d = new_checkpoint_q;
        rem              = '0;
        walking          = 1'b0;
        rec_ready        = 1'b0;
        rec_state        = 1'b0;
        in_reclaim       = 1'b0;
        rht_set_ptr      = 1'b0;
        new_pointer      = '0;
        walk_valid       = '0;
        walk_idx         = '0;
        target_inc       = target_q + id_t'(1);

        case (state_q)
            S_IDLE: begin
                rec_ready = 1'b1;
                if (rec_en) begin
                    target_d         = rec_rht_id;
                    // Checkpoint slot is the ticket's block number, truncated to the checkpoint table size.
                    new_checkpoint_d = C_ADDR'(rec_rht_id >> LOG_K);
                    walk_point_d     = rec_rht_id & BASE_MASK;
                    state_d          = S_RESTORE;
                end
            end
            S_RESTORE: begin
                rec_state = 1'b1;
                walking   = 1'b1;
                rem       = target_q - walk_point_q;
                if (!walk_stall) begin
                    if (rem < WALK_STEP) begin
                        walk_point_d = target_inc;
                        state_d      = (target_inc == rht_id_out) ? S_DONE : S_RECLAIM;
                    end else begin
                        walk_point_d = walk_point_q + WALK_STEP;
                    end
                end
            end
            S_RECLAIM: begin
                rec_state  = 1'b1;
                in_reclaim = 1'b1;
                walking    = 1'b1;
                rem        = rht_id_out - id_t'(1) - walk_point_q;
                if (!walk_stall) begin
                    if (rem < WALK_STEP) state_d = S_DONE;
                    else                 walk_point_d = walk_point_q + WALK_STEP;
                end
            end
            S_DONE: begin
                rec_state   = 1'b1;
                rht_set_ptr = 1'b1;
                new_pointer = target_inc;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Lanes beyond the remaining distance stay invalid so a phase never spills into the next.
        if (walking) begin
            for (int i = 0; i < WALK_W; i++) begin
                walk_idx[i*RHT_ID_WIDTH +: RHT_ID_WIDTH] = walk_point_q + id_t'(i);
                walk_valid[i] = !walk_stall && (id_t'(i) <= rem);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            walk_point_q     <= '0;
            target_q         <= '0;
            new_checkpoint_q <= '0;
        end else begin
            state_q          <= state_d;
            walk_point_q     <= walk_point_d;
            target_q         <= target_d;
            new_checkpoint_q <= new_checkpoint_d;
        end
    end

    assign new_checkpoint = new_checkpoint_q;

`ifdef WALK_PERF_EN
    logic [31:0] perf_rec_cnt_q, perf_rec_cnt_d;
    logic [31:0] perf_walk_cyc_q, perf_walk_cyc_d;

    always_comb begin
        perf_rec_cnt_d  = perf_rec_cnt_q;
        perf_walk_cyc_d = perf_walk_cyc_q;
        if (rec_ready && rec_en && perf_rec_cnt_q != '1) perf_rec_cnt_d = perf_rec_cnt_q + 32'd1;
        if (rec_state && perf_walk_cyc_q != '1)          perf_walk_cyc_d = perf_walk_cyc_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_rec_cnt_q  <= '0;
            perf_walk_cyc_q <= '0;
        end else begin
            perf_rec_cnt_q  <= perf_rec_cnt_d;
            perf_walk_cyc_q <= perf_walk_cyc_d;
        end
    end

    assign perf_rec_cnt  = perf_rec_cnt_q;
    assign perf_walk_cyc = perf_walk_cyc_q;
`endif

endmodule

// File: tb/tb_walk_multi.sv
// Self-checking bench for walk_multi: queue-based reference model compared every cycle, plus directed literal checks.
module tb_walk_multi;

    localparam int W  = 8;
    localparam int WW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          rec_en;
    logic [W-1:0]  rec_rht_id;
    logic [W-1:0]  rht_id_out;
    logic          walk_stall;
    logic          rec_ready, rec_state, in_reclaim, rht_set_ptr;
    logic [WW-1:0] walk_valid;
    logic [WW*W-1:0] walk_idx;
    logic [1:0]    new_checkpoint;
    logic [W-1:0]  new_pointer;

    walk_multi #(.RHT_ID_WIDTH(8), .C_ADDR(2), .K(32), .WALK_W(2)) dut (
        .clk(clk), .rst(rst), .rec_en(rec_en), .rec_rht_id(rec_rht_id),
        .rht_id_out(rht_id_out), .walk_stall(walk_stall), .rec_ready(rec_ready),
        .rec_state(rec_state), .in_reclaim(in_reclaim), .walk_valid(walk_valid),
        .walk_idx(walk_idx), .new_checkpoint(new_checkpoint), .rht_set_ptr(rht_set_ptr),
        .new_pointer(new_pointer)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: the walk is a list of tickets still to emit in the current phase.
    typedef enum {P_IDLE, P_RESTORE, P_RECLAIM, P_DONE} phase_t;
    phase_t     m_ph = P_IDLE;
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_target = '0;
    logic [1:0] m_ckpt = '0;
    logic [W-1:0] mj;

    always @(posedge clk) begin
        if (rst) begin
            m_ph = P_IDLE; m_q.delete(); m_target = '0; m_ckpt = '0;
        end else begin
            case (m_ph)
                P_IDLE: if (rec_en) begin
                    m_target = rec_rht_id;
                    m_ckpt   = 2'((rec_rht_id / 32) % 4);
                    m_q.delete();
                    for (mj = rec_rht_id - (rec_rht_id % 32); mj != rec_rht_id; mj++) m_q.push_back(mj);
                    m_q.push_back(rec_rht_id);
                    m_ph = P_RESTORE;
                end
                P_RESTORE, P_RECLAIM: if (!walk_stall) begin
                    repeat (WW) if (m_q.size() > 0) void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        if (m_ph == P_RESTORE) begin
                            for (mj = m_target + 8'd1; mj != rht_id_out; mj++) m_q.push_back(mj);
                            m_ph = (m_q.size() == 0) ? P_DONE : P_RECLAIM;
                        end else begin
                            m_ph = P_DONE;
                        end
                    end
                end
                P_DONE: m_ph = P_IDLE;
                default: m_ph = P_IDLE;
            endcase
        end
    end

    bit chk_en = 0;
    logic [WW-1:0]   exp_valid;
    logic [WW*W-1:0] exp_idx;
    bit              exp_walk;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_walk  = (m_ph == P_RESTORE) || (m_ph == P_RECLAIM);
            exp_valid = '0;
            exp_idx   = '0;
            if (exp_walk) begin
                for (int i = 0; i < WW; i++) begin
                    exp_idx[i*W +: W] = W'(m_q[0] + i);
                    exp_valid[i] = !walk_stall && (i < m_q.size());
                end
            end
            check("rec_ready", rec_ready, m_ph == P_IDLE);
            check("rec_state", rec_state, m_ph != P_IDLE);
            check("in_reclaim", in_reclaim, m_ph == P_RECLAIM);
            check("walk_valid", walk_valid, exp_valid);
            check("rht_set_ptr", rht_set_ptr, m_ph == P_DONE);
            check("new_checkpoint", new_checkpoint, m_ckpt);
            if (exp_walk) check("walk_idx", walk_idx, exp_idx);
            if (m_ph == P_DONE) check("new_pointer", new_pointer, W'(m_target + 8'd1));
        end
    end

    logic [WW-1:0]   lg_valid[0:31];
    logic [WW*W-1:0] lg_idx[0:31];
    bit              saw_reclaim;
    logic [W-1:0]    got_ptr;
    logic [1:0]      got_ckpt;
    int              ncyc;

    // Called just after a rising edge; returns the cycle number (1 = first after accept) of the DONE pulse.
    task automatic run_rec(input logic [W-1:0] id, input logic [W-1:0] tail, input int stall_pct,
                           input int st_from, input int st_len, output int cyc);
        int  c = 0;
        bit  seen = 0;
        cyc = 0;
        while (!rec_ready && c < 200) begin @(posedge clk); #1; c++; end
        rec_en = 1'b1; rec_rht_id = id; rht_id_out = tail; walk_stall = 1'b0;
        @(posedge clk); #1;
        saw_reclaim = 0;
        for (int k = 1; k <= 600 && !seen; k++) begin
            walk_stall = (k >= st_from && k < st_from + st_len) || ($urandom_range(99) < stall_pct);
            rec_en     = ($urandom_range(3) == 0);
            rec_rht_id = W'($urandom);
            @(negedge clk);
            if (k < 32) begin lg_valid[k] = walk_valid; lg_idx[k] = walk_idx; end
            if (in_reclaim) saw_reclaim = 1;
            if (rht_set_ptr) begin seen = 1; cyc = k; got_ptr = new_pointer; got_ckpt = new_checkpoint; end
            @(posedge clk); #1;
        end
        rec_en = 1'b0; walk_stall = 1'b0;
        check("done_seen_before_timeout", seen, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; rec_en = 1'b0; rec_rht_id = '0; rht_id_out = '0; walk_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_rec_ready", rec_ready, 1'b1);
        check("reset_rec_state", rec_state, 1'b0);
        check("reset_walk_valid", walk_valid, 2'b00);
        check("reset_walk_idx", walk_idx, 16'h0000);
        check("reset_set_ptr", rht_set_ptr, 1'b0);
        check("reset_new_pointer", new_pointer, 8'h00);
        check("reset_checkpoint", new_checkpoint, 2'd0);
        chk_en = 1;
        @(posedge clk); #1;

        // Full RESTORE then RECLAIM.
        run_rec(8'h25, 8'h2A, 0, 0, 0, ncyc);
        check("t1_cycles", ncyc, 6);
        check("t1_lanes_c1", {lg_valid[1], lg_idx[1]}, {2'b11, 8'h21, 8'h20});
        check("t1_lanes_c3", lg_idx[3], {8'h25, 8'h24});
        check("t1_lanes_c5", lg_idx[5], {8'h29, 8'h28});
        check("t1_new_pointer", got_ptr, 8'h26);
        check("t1_checkpoint", got_ckpt, 2'd1);

        // Partial last RESTORE beat.
        run_rec(8'h24, 8'h27, 0, 0, 0, ncyc);
        check("t2_cycles", ncyc, 5);
        check("t2_partial_lane", {lg_valid[3], lg_idx[3][7:0]}, {2'b01, 8'h24});
        check("t2_reclaim_lanes", lg_idx[4], {8'h26, 8'h25});
        check("t2_new_pointer", got_ptr, 8'h25);

        // No RECLAIM phase.
        run_rec(8'h25, 8'h26, 0, 0, 0, ncyc);
        check("t3_cycles", ncyc, 4);
        check("t3_no_reclaim", saw_reclaim, 1'b0);

        // Wrap through 0xFF.
        run_rec(8'hE3, 8'h02, 0, 0, 0, ncyc);
        check("t4_cycles", ncyc, 18);
        check("t4_new_pointer", got_ptr, 8'hE4);
        check("t4_checkpoint", got_ckpt, 2'd3);
        check("t4_wrap_lanes", lg_idx[17], {8'h01, 8'h00});

        // Two stall cycles at RECLAIM lanes (28,29).
        run_rec(8'h25, 8'h2A, 0, 5, 2, ncyc);
        check("t5_cycles", ncyc, 8);
        check("t5_stalled", {lg_valid[5], lg_valid[6]}, 4'b0000);
        check("t5_held_idx", lg_idx[6], {8'h29, 8'h28});
        check("t5_resume", {lg_valid[7], lg_idx[7]}, {2'b11, 8'h29, 8'h28});

        // Reset mid-RESTORE aborts without a DONE pulse.
        rec_en = 1'b1; rec_rht_id = 8'h25; rht_id_out = 8'h2A;
        @(posedge clk); #1 rec_en = 1'b0;
        @(posedge clk); #1 rec_en = 1'b1; rec_rht_id = 8'h77; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; rec_en = 1'b0;
        @(negedge clk);
        check("t6_ready_after_rst", rec_ready, 1'b1);
        check("t6_state_after_rst", rec_state, 1'b0);
        check("t6_ckpt_after_rst", new_checkpoint, 2'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t6_no_set_ptr", rht_set_ptr, 1'b0);
        end
        @(posedge clk); #1;

        // Randomized recoveries with random stalls and ignored mid-walk requests.
        for (int r = 0; r < 40; r++) begin
            logic [W-1:0] id;
            id = W'($urandom);
            run_rec(id, W'(id + 1 + $urandom_range(0, 40)), 30, 0, 0, ncyc);
        end

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
